// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, baud divider helper
// and framing constants.
// Optional feature macro: UART_TX_FIFO_PARITY_EN adds an even-parity state.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LEVEL = 1'b1;

`ifdef UART_TX_FIFO_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;
`endif

    // System clocks per serial bit, truncated.
    function automatic int unsigned calc_clks_per_bit(input int unsigned clock_mhz,
                                                      input int unsigned bit_rate);
        return (clock_mhz * 32'd1_000_000) / bit_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
// Ports: clk, rst_n (async, active-low), i_push/i_data write side,
//        i_pop/o_data read side (o_data shows the head entry),
//        o_full, o_empty, o_level (entries stored).
// A push while full is dropped even if a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      w_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Pointer difference including the wrap bit gives 0..DEPTH.
    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign o_level   = w_level;
    assign o_full    = (w_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes pushed into a FIFO are drained onto
// uart_txd as back-to-back 8N1 frames (8E1 with UART_TX_FIFO_PARITY_EN).
// Ports: clk, rst_n (async, active-low); wr_en/wr_data push a byte;
//        clr_overflow clears the sticky drop flag; full/empty/level report
//        FIFO occupancy; overflow is sticky; busy = serializer active or
//        bytes queued; irq_tx_done = !busy; uart_txd is the serial line.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_MHZ = 50,
    parameter int unsigned BIT_RATE  = 9600,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [DATA_BITS-1:0]   wr_data,
    input  logic                   clr_overflow,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   busy,
    output logic                   irq_tx_done,
    output logic                   uart_txd
);

    localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLOCK_MHZ, BIT_RATE);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W        = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    tx_state_t            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_txd;
    logic                 r_overflow;
`ifdef UART_TX_FIFO_PARITY_EN
    logic                 r_parity;
`endif

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_bit_end;
    logic [DATA_BITS-1:0] w_rd_data;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (wr_en),
        .i_data  (wr_data),
        .i_pop   (w_pop),
        .o_data  (w_rd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign w_bit_end = (r_cnt == CNT_LAST);
    // Pop from IDLE, or at the last stop-bit cycle to chain frames without a gap.
    assign w_pop = !w_empty && ((r_state == ST_IDLE) ||
                                ((r_state == ST_STOP) && w_bit_end));

    assign full        = w_full;
    assign empty       = w_empty;
    assign overflow    = r_overflow;
    assign busy        = (r_state != ST_IDLE) || !w_empty;
    assign irq_tx_done = !busy;
    assign uart_txd    = r_txd;

    // Sticky overflow; a dropped write wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (wr_en && w_full) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    // Serializer FSM with baud counter and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= IDLE_LEVEL;
`ifdef UART_TX_FIFO_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_txd <= IDLE_LEVEL;
                    r_cnt <= '0;
                    if (w_pop) begin
                        r_shift <= w_rd_data;
`ifdef UART_TX_FIFO_PARITY_EN
                        r_parity <= ^w_rd_data;
`endif
                        r_txd   <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_txd     <= r_shift[0];
                        r_state   <= ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == IDX_LAST) begin
`ifdef UART_TX_FIFO_PARITY_EN
                            r_txd   <= r_parity;
                            r_state <= ST_PARITY;
`else
                            r_txd   <= IDLE_LEVEL;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                            r_shift   <= r_shift >> 1;
                            r_txd     <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_TX_FIFO_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_txd   <= IDLE_LEVEL;
                        r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_pop) begin
                            r_shift <= w_rd_data;
`ifdef UART_TX_FIFO_PARITY_EN
                            r_parity <= ^w_rd_data;
`endif
                            r_txd   <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_txd   <= IDLE_LEVEL;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: CLOCK_MHZ=1, BIT_RATE=250000 (4 clocks/bit), DEPTH=4.
// A serial monitor checks every frame bit-exact against a scoreboard queue
// filled when bytes are written; occupancy is checked from a vector table.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
`ifdef UART_TX_FIFO_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_overflow;
    logic       full;
    logic       empty;
    logic [2:0] level;
    logic       overflow;
    logic       busy;
    logic       irq_tx_done;
    logic       uart_txd;

    uart_tx_fifo #(
        .CLOCK_MHZ (1),
        .BIT_RATE  (250000),
        .DEPTH     (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .clr_overflow (clr_overflow),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .busy         (busy),
        .irq_tx_done  (irq_tx_done),
        .uart_txd     (uart_txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_pass   = 0;
    int         n_checks = 0;
    int         frames_detected = 0;
    logic [7:0] sb[$];
    int         starts[$];

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       clr;
        logic       accept;
        logic       e_full;
        logic       e_empty;
        int         e_level;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // Decodes frames on uart_txd, comparing every cycle against the expected bit.
    task automatic monitor();
        logic [10:0] fr;
        logic [7:0]  d;
        int          errs;
        bit          abort;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_txd === 1'b0) begin
                frames_detected++;
                starts.push_back(cyc);
                check("frame_expected", (sb.size() != 0) ? 1 : 0, 1);
                d = (sb.size() != 0) ? sb[0] : 8'h00;
                fr = '1;
                fr[0] = 1'b0;
                fr[8:1] = d;
`ifdef UART_TX_FIFO_PARITY_EN
                fr[9] = ^d;
`endif
                errs  = 0;
                abort = 1'b0;
                for (int off = 0; off < FRAME_CYC; off++) begin
                    if (off != 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        abort = 1'b1;
                        break;
                    end
                    if (uart_txd !== fr[4'(off / CPB)]) errs++;
                end
                if (!abort) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                    check($sformatf("frame_bits_%02h", d), errs, 0);
                end
            end
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", int'(busy), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_txd"},   int'(uart_txd), 1);
        check({tag, "_empty"}, int'(empty), 1);
        check({tag, "_full"},  int'(full), 0);
        check({tag, "_level"}, int'(level), 0);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_irq"},   int'(irq_tx_done), 1);
        check({tag, "_ovf"},   int'(overflow), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int fb;

        vecs[0] = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
        vecs[1] = '{1'b1, 8'h21, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
        vecs[2] = '{1'b1, 8'h32, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0};
        vecs[3] = '{1'b1, 8'h43, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0};
        vecs[4] = '{1'b1, 8'h54, 1'b0, 1'b1, 1'b1, 1'b0, 4, 1'b0};
        vecs[5] = '{1'b1, 8'h65, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0};
        vecs[7] = '{1'b1, 8'h76, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0};

        rst_n        = 1'b0;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        clr_overflow = 1'b0;

        fork
            monitor();
        join_none

        // Reset values, during and after reset.
        repeat (3) @(negedge clk);
        check_reset_state("in_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("after_reset");

        // Single byte 0xA5 from idle.
        wr_en = 1'b1; wr_data = 8'hA5; sb.push_back(8'hA5);
        @(negedge clk);
        wr_en = 1'b0;
        t0 = cyc;
        check("a5_txd_still_high", int'(uart_txd), 1);
        check("a5_empty_after_write", int'(empty), 0);
        check("a5_level_after_write", int'(level), 1);
        check("a5_busy", int'(busy), 1);
        check("a5_irq_low", int'(irq_tx_done), 0);
        @(negedge clk);
        check("a5_start_bit", int'(uart_txd), 0);
        check("a5_empty_after_pop", int'(empty), 1);
        check("a5_level_after_pop", int'(level), 0);
        wait_idle(200);
        check("a5_busy_cycles", cyc - t0, FRAME_CYC + 1);
        check("a5_irq_done", int'(irq_tx_done), 1);
        check("a5_sb_drained", sb.size(), 0);

        // Three back-to-back bytes: contiguous frames.
        starts.delete();
        wr_en = 1'b1; wr_data = 8'h01; sb.push_back(8'h01);
        @(negedge clk);
        t0 = cyc;
        check("burst3_level_1", int'(level), 1);
        wr_data = 8'h02; sb.push_back(8'h02);
        @(negedge clk);
        check("burst3_level_2", int'(level), 1);
        wr_data = 8'h03; sb.push_back(8'h03);
        @(negedge clk);
        wr_en = 1'b0;
        check("burst3_level_3", int'(level), 2);
        wait_idle(500);
        check("burst3_busy_cycles", cyc - t0, 3 * FRAME_CYC + 1);
        check("burst3_frames", starts.size(), 3);
        if (starts.size() == 3) begin
            check("burst3_gap_1", starts[1] - starts[0], FRAME_CYC);
            check("burst3_gap_2", starts[2] - starts[1], FRAME_CYC);
        end
        check("burst3_sb_drained", sb.size(), 0);

        // Table: fill past full, overflow set/clear, set wins over clear.
        starts.delete();
        for (int i = 0; i < 9; i++) begin
            wr_en        = vecs[i].wr;
            wr_data      = vecs[i].data;
            clr_overflow = vecs[i].clr;
            if (vecs[i].accept) sb.push_back(vecs[i].data);
            @(negedge clk);
            if (i == 0) t0 = cyc;
            check($sformatf("vec%0d_full", i),  int'(full),     int'(vecs[i].e_full));
            check($sformatf("vec%0d_empty", i), int'(empty),    int'(vecs[i].e_empty));
            check($sformatf("vec%0d_level", i), int'(level),    vecs[i].e_level);
            check($sformatf("vec%0d_ovf", i),   int'(overflow), int'(vecs[i].e_ovf));
            check($sformatf("vec%0d_busy", i),  int'(busy),     1);
        end
        wr_en = 1'b0; clr_overflow = 1'b0;
        wait_idle(800);
        check("fill_busy_cycles", cyc - t0, 5 * FRAME_CYC + 1);
        check("fill_frames", starts.size(), 5);
        if (starts.size() == 5) check("fill_span", starts[4] - starts[0], 4 * FRAME_CYC);
        check("fill_sb_drained", sb.size(), 0);

        // Reset in the middle of DATA of 0x55 with two bytes queued.
        wr_en = 1'b1; wr_data = 8'h55; sb.push_back(8'h55);
        @(negedge clk);
        wr_data = 8'h11; sb.push_back(8'h11);
        @(negedge clk);
        wr_data = 8'h22; sb.push_back(8'h22);
        @(negedge clk);
        wr_en = 1'b0;
        check("rst_level_queued", int'(level), 2);
        repeat (8) @(negedge clk);
        check("rst_txd_data_bit1", int'(uart_txd), 0);
        #1 rst_n = 1'b0;
        #1;
        sb.delete();
        fb = frames_detected;
        check("rst_async_txd", int'(uart_txd), 1);
        check("rst_async_level", int'(level), 0);
        check("rst_async_empty", int'(empty), 1);
        check("rst_async_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("rst_no_new_frames", frames_detected, fb);
        check("rst_txd_idle", int'(uart_txd), 1);
        check("rst_level_after", int'(level), 0);
        check("rst_irq_after", int'(irq_tx_done), 1);

`ifdef UART_TX_FIFO_PARITY_EN
        // Parity bit values: 0x07 -> 1, 0x03 -> 0 (checked bit-exact by the monitor).
        wr_en = 1'b1; wr_data = 8'h07; sb.push_back(8'h07);
        @(negedge clk);
        wr_en = 1'b0;
        t0 = cyc;
        wait_idle(200);
        check("par07_busy_cycles", cyc - t0, 45);
        wr_en = 1'b1; wr_data = 8'h03; sb.push_back(8'h03);
        @(negedge clk);
        wr_en = 1'b0;
        t0 = cyc;
        wait_idle(200);
        check("par03_busy_cycles", cyc - t0, 45);
        check("par_sb_drained", sb.size(), 0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
